// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin word scheduler feeding a shared UART byte transmitter
// Optional header byte {4'hA, grant_id} before each word: define UART_TX_SCHED_HEADER_EN.
module uart_tx_scheduler #(
  parameter int N_REQ = 2,
  parameter int W     = 16,
  parameter int CNT_W = 4
) (
  input  logic                                   iCE_CLK,
  input  logic                                   rst,
  input  logic [N_REQ-1:0]                       req,
  input  logic [N_REQ*W-1:0]                     req_data,
  output logic [N_REQ-1:0]                       ack,
  input  logic                                   is_transmitting,
  output logic [7:0]                             tx_byte,
  output logic                                   tx_valid,
  output logic                                   busy,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id
);

  localparam int GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NBYTES = W / 8;
`ifdef UART_TX_SCHED_HEADER_EN
  localparam int TOTAL  = NBYTES + 1;
`else
  localparam int TOTAL  = NBYTES;
`endif

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]      rr_q, rr_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               tx_valid_q, tx_valid_d;
  logic [N_REQ-1:0]   ack_q, ack_d;

  logic [W-1:0]       words [N_REQ];
  logic               found;
  logic [GW-1:0]      win;
  logic [GW:0]        sum;

  for (genvar i = 0; i < N_REQ; i++) begin : g_words
    assign words[i] = req_data[i*W +: W];
  end

  always_ff @(posedge iCE_CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
      grant_q    <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = 1'b0;
    ack_d      = '0;
    found      = 1'b0;
    win        = '0;
    sum        = '0;

    // Cyclic search starting at the round-robin pointer.
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_q} + (GW+1)'(k);
      if (sum >= (GW+1)'(N_REQ)) sum = sum - (GW+1)'(N_REQ);
      if (!found && req[sum[GW-1:0]]) begin
        found = 1'b1;
        win   = sum[GW-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if (found && !is_transmitting) begin
          grant_d    = win;
          tx_valid_d = 1'b1;
          cnt_d      = CNT_W'(1);
          state_d    = WAIT_BUSY;
`ifdef UART_TX_SCHED_HEADER_EN
          tx_byte_d  = {4'hA, 4'(win)};
          shift_d    = words[win];
`else
          tx_byte_d  = words[win][7:0];
          shift_d    = words[win] >> 8;
`endif
        end
      end
      WAIT_BUSY: begin
        if (is_transmitting) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!is_transmitting) begin
          if (cnt_q < CNT_W'(TOTAL)) begin
            // shift_q always holds the next unsent byte in its low lane.
            tx_byte_d  = shift_q[7:0];
            shift_d    = shift_q >> 8;
            tx_valid_d = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            state_d    = WAIT_BUSY;
          end else begin
            ack_d[grant_q] = 1'b1;
            rr_d    = (grant_q == GW'(N_REQ-1)) ? '0 : grant_q + GW'(1);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_byte  = tx_byte_q;
  assign tx_valid = tx_valid_q;
  assign ack      = ack_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed bench for uart_tx_scheduler with a 10-cycle UART busy model
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] req_data;
  logic [1:0]  ack;
  logic        is_transmitting;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        busy;
  logic [0:0]  grant_id;

  logic        force_busy;
  logic        uart_busy = 1'b0;
  int          uart_cnt  = 0;
  int          viol      = 0;
  int          ev [$];
  int          exp_q [$];
  int          checks    = 0;
  int          failures  = 0;

  always #5 clk = ~clk;

  assign is_transmitting = uart_busy | force_busy;

  uart_tx_scheduler #(.N_REQ(2), .W(16), .CNT_W(4)) dut (
    .iCE_CLK         (clk),
    .rst             (rst),
    .req             (req),
    .req_data        (req_data),
    .ack             (ack),
    .is_transmitting (is_transmitting),
    .tx_byte         (tx_byte),
    .tx_valid        (tx_valid),
    .busy            (busy),
    .grant_id        (grant_id)
  );

  // UART model and event log: bytes logged as value, acks as 256+mask.
  always @(negedge clk) begin
    if (tx_valid && uart_busy) viol = viol + 1;
    if (tx_valid) ev.push_back(int'(tx_byte));
    if (ack != 2'b00) ev.push_back(256 + int'(ack));
    if (tx_valid) uart_cnt = 10;
    else if (uart_cnt > 0) uart_cnt = uart_cnt - 1;
    uart_busy = (uart_cnt > 0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks = checks + 1;
    if (got !== expv) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic compare_log(input string tag);
    check_eq($sformatf("%s_len", tag), ev.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < ev.size()) check_eq($sformatf("%s_ev%0d", tag, i), ev[i], exp_q[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    while (is_transmitting && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("idle_wait_timeout", 1, 0);
    @(negedge clk);
    ev.delete();
  endtask

  // Waits for n acks; auto_clr drops each acked req bit, otherwise all req drop on the last ack.
  task automatic wait_acks(input int n, input bit auto_clr, input string tag);
    int seen, cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ack != 2'b00) begin
        seen++;
        if (auto_clr) req = req & ~ack;
        if (seen == n) req = 2'b00;
      end
    end
    if (seen < n) begin
      check_eq($sformatf("%s_ack_timeout", tag), seen, n);
      req = 2'b00;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tx_valid(input string tag);
    int cyc;
    cyc = 0;
    while (!tx_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!tx_valid) check_eq($sformatf("%s_txv_timeout", tag), 0, 1);
  endtask

  initial begin
    rst        = 1'b1;
    req        = 2'b00;
    req_data   = 32'h0;
    force_busy = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_byte", tx_byte, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_id", grant_id, 0);
    @(negedge clk);
    rst = 1'b0;
    ev.delete();

    // 1: single word, first byte one cycle after req sampled
    req_data = {16'h0000, 16'hBEEF};
    req = 2'b01;
    @(posedge clk);
    #1;
    check_eq("t1_first_valid", tx_valid, 1);
    check_eq("t1_first_byte", tx_byte, 8'hEF);
    wait_acks(1, 1'b1, "t1");
    exp_q = '{32'hEF, 32'hBE, 256 + 1};
    compare_log("t1");

    // 2: contention from pointer 0
    do_reset();
    idle_wait();
    req_data = {16'h5678, 16'h1234};
    req = 2'b11;
    wait_acks(2, 1'b1, "t2");
    exp_q = '{32'h34, 32'h12, 256 + 1, 32'h78, 32'h56, 256 + 2};
    compare_log("t2");

    // 2b: both held high -> strict alternation 0,1,0
    idle_wait();
    req = 2'b11;
    wait_acks(3, 1'b0, "t2b");
    exp_q = '{32'h34, 32'h12, 256 + 1, 32'h78, 32'h56, 256 + 2, 32'h34, 32'h12, 256 + 1};
    compare_log("t2b");
    check_eq("t2b_grant_id", grant_id, 0);

    // 3: foreign byte in flight blocks the start
    idle_wait();
    force_busy = 1'b1;
    req_data = {16'h0000, 16'h1357};
    req = 2'b01;
    repeat (6) @(negedge clk);
    check_eq("t3_blocked_events", ev.size(), 0);
    check_eq("t3_blocked_busy", busy, 0);
    force_busy = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t3_start_valid", tx_valid, 1);
    check_eq("t3_start_byte", tx_byte, 8'h57);
    wait_acks(1, 1'b1, "t3");
    exp_q = '{32'h57, 32'h13, 256 + 1};
    compare_log("t3");

    // 4: reset mid-word, then restart from byte0
    idle_wait();
    req_data = {16'h0000, 16'hCAFE};
    req = 2'b01;
    wait_tx_valid("t4");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t4_rst_tx_valid", tx_valid, 0);
    check_eq("t4_rst_ack", ack, 0);
    check_eq("t4_rst_busy", busy, 0);
    @(negedge clk);
    ev.delete();
    rst = 1'b0;
    wait_acks(1, 1'b1, "t4");
    exp_q = '{32'hFE, 32'hCA, 256 + 1};
    compare_log("t4");

    // 5: data and req changes after grant are ignored
    idle_wait();
    req_data = {16'h0000, 16'hA55A};
    req = 2'b01;
    wait_tx_valid("t5");
    req_data = 32'h0;
    req = 2'b00;
    wait_acks(1, 1'b1, "t5");
    exp_q = '{32'h5A, 32'hA5, 256 + 1};
    compare_log("t5");

`ifdef UART_TX_SCHED_HEADER_EN
    // 6: header byte precedes the word
    do_reset();
    idle_wait();
    req_data = {16'h00FF, 16'h0000};
    req = 2'b10;
    wait_acks(1, 1'b1, "t6");
    exp_q = '{32'hA1, 32'hFF, 32'h00, 256 + 2};
    compare_log("t6");
`endif

    check_eq("no_tx_while_busy", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
